execute_stage: RTL and testbench

Execute stage of the five-stage RISC-V pipeline. It sits directly downstream of the decode stage and consumes its ID/EX register outputs. It selects forwarded operands and runs the ALU. It resolves branches and jumps, producing the redirect target and taken flag for fetch and the hazard unit. Results are captured in the EX/MEM pipeline register that feeds the memory stage.

---
 rtl/execute_stage.sv | 161 ++++++++++++++++
 tb/tb_execute_stage.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_stage.sv
// Execute stage: operand forwarding, ALU, branch/jump resolution and the EX/MEM
// pipeline register feeding the memory stage.
module execute_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteE,
  input  logic        ALUSrcE,
  input  logic        MemWriteE,
  input  logic        MemReadE,
  input  logic        ResultSrcE,
  input  logic [2:0]  BranchE,
  input  logic [2:0]  ALUControlE,
  input  logic [31:0] RD1_E,
  input  logic [31:0] RD2_E,
  input  logic [31:0] ImmExtE,
  input  logic [31:0] PCE,
  input  logic [31:0] PCPlus4E,
  input  logic [4:0]  RD_E,
  input  logic [1:0]  ForwardAE,
  input  logic [1:0]  ForwardBE,
  input  logic [31:0] ResultW,
  input  logic        StallM,
  input  logic        FlushM,
  output logic        PCSrcE,
  output logic [31:0] PCTargetE,
  output logic        RegWriteM,
  output logic        MemWriteM,
  output logic        MemReadM,
  output logic        ResultSrcM,
  output logic [31:0] ALUResultM,
  output logic [31:0] WriteDataM,
  output logic [31:0] PCPlus4M,
  output logic [4:0]  RD_M
);

  typedef enum logic [2:0] {
    BrNone = 3'b000,
    BrEq   = 3'b001,
    BrNe   = 3'b010,
    BrLt   = 3'b011,
    BrGe   = 3'b100,
    BrJal  = 3'b101,
    BrJalr = 3'b110,
    BrRsvd = 3'b111
  } branch_e;

  typedef enum logic [2:0] {
    AluAdd = 3'b000,
    AluSub = 3'b001,
    AluAnd = 3'b010,
    AluOr  = 3'b011,
    AluXor = 3'b100,
    AluSlt = 3'b101,
    AluSll = 3'b110,
    AluSrl = 3'b111
  } alu_op_e;

  logic [31:0] src_a;
  logic [31:0] fwd_b;
  logic [31:0] src_b;
  logic [31:0] alu_out;
  logic [31:0] ex_result;
  logic        cmp_eq;
  logic        cmp_lt;
  logic        is_jump;

  // Encoding 11 falls back to the register value.
  always_comb begin
    unique case (ForwardAE)
      2'b01:   src_a = ResultW;
      2'b10:   src_a = ALUResultM;
      default: src_a = RD1_E;
    endcase
    unique case (ForwardBE)
      2'b01:   fwd_b = ResultW;
      2'b10:   fwd_b = ALUResultM;
      default: fwd_b = RD2_E;
    endcase
  end

  assign src_b = ALUSrcE ? ImmExtE : fwd_b;

  always_comb begin
    alu_out = 32'd0;
    unique case (alu_op_e'(ALUControlE))
      AluAdd:  alu_out = src_a + src_b;
      AluSub:  alu_out = src_a - src_b;
      AluAnd:  alu_out = src_a & src_b;
      AluOr:   alu_out = src_a | src_b;
      AluXor:  alu_out = src_a ^ src_b;
      AluSlt:  alu_out = {31'd0, $signed(src_a) < $signed(src_b)};
      AluSll:  alu_out = src_a << src_b[4:0];
      AluSrl:  alu_out = src_a >> src_b[4:0];
      default: alu_out = 32'd0;
    endcase
  end

  // Branch compare always sees the forwarded rs2, never the immediate.
  assign cmp_eq = (src_a == fwd_b);
  assign cmp_lt = ($signed(src_a) < $signed(fwd_b));

  always_comb begin
    PCSrcE  = 1'b0;
    is_jump = 1'b0;
    unique case (branch_e'(BranchE))
      BrEq:    PCSrcE = cmp_eq;
      BrNe:    PCSrcE = !cmp_eq;
      BrLt:    PCSrcE = cmp_lt;
      BrGe:    PCSrcE = !cmp_lt;
      BrJal,
      BrJalr: begin
        PCSrcE  = 1'b1;
        is_jump = 1'b1;
      end
      default: PCSrcE = 1'b0;
    endcase
  end

  always_comb begin
    if (branch_e'(BranchE) == BrJalr) begin
      PCTargetE = (src_a + ImmExtE) & 32'hFFFF_FFFE;
    end else begin
      PCTargetE = PCE + ImmExtE;
    end
  end

  assign ex_result = is_jump ? PCPlus4E : alu_out;

  // Flush has priority over stall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      MemReadM   <= 1'b0;
      ResultSrcM <= 1'b0;
      ALUResultM <= 32'd0;
      WriteDataM <= 32'd0;
      PCPlus4M   <= 32'd0;
      RD_M       <= 5'd0;
    end else if (FlushM) begin
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      MemReadM   <= 1'b0;
      ResultSrcM <= 1'b0;
      ALUResultM <= 32'd0;
      WriteDataM <= 32'd0;
      PCPlus4M   <= 32'd0;
      RD_M       <= 5'd0;
    end else if (!StallM) begin
      RegWriteM  <= RegWriteE;
      MemWriteM  <= MemWriteE;
      MemReadM   <= MemReadE;
      ResultSrcM <= ResultSrcE;
      ALUResultM <= ex_result;
      WriteDataM <= fwd_b;
      PCPlus4M   <= PCPlus4E;
      RD_M       <= RD_E;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: directed cases plus randomized traffic checked against
// a behavioural model of the EX/MEM state.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        RegWriteE, ALUSrcE, MemWriteE, MemReadE, ResultSrcE;
  logic [2:0]  BranchE, ALUControlE;
  logic [31:0] RD1_E, RD2_E, ImmExtE, PCE, PCPlus4E, ResultW;
  logic [4:0]  RD_E;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        StallM, FlushM;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        RegWriteM, MemWriteM, MemReadM, ResultSrcM;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
  logic [4:0]  RD_M;

  int total = 0;
  int bad   = 0;

  // Model of the EX/MEM register contents.
  logic        m_rw, m_mw, m_mr, m_rs;
  logic [31:0] m_alu, m_wd, m_pc4;
  logic [4:0]  m_rd;
  logic        e_taken;
  logic [31:0] e_target, e_result, e_store;

  always #5 clk = ~clk;

  execute_stage dut (
    .clk        (clk),
    .rst        (rst),
    .RegWriteE  (RegWriteE),
    .ALUSrcE    (ALUSrcE),
    .MemWriteE  (MemWriteE),
    .MemReadE   (MemReadE),
    .ResultSrcE (ResultSrcE),
    .BranchE    (BranchE),
    .ALUControlE(ALUControlE),
    .RD1_E      (RD1_E),
    .RD2_E      (RD2_E),
    .ImmExtE    (ImmExtE),
    .PCE        (PCE),
    .PCPlus4E   (PCPlus4E),
    .RD_E       (RD_E),
    .ForwardAE  (ForwardAE),
    .ForwardBE  (ForwardBE),
    .ResultW    (ResultW),
    .StallM     (StallM),
    .FlushM     (FlushM),
    .PCSrcE     (PCSrcE),
    .PCTargetE  (PCTargetE),
    .RegWriteM  (RegWriteM),
    .MemWriteM  (MemWriteM),
    .MemReadM   (MemReadM),
    .ResultSrcM (ResultSrcM),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .PCPlus4M   (PCPlus4M),
    .RD_M       (RD_M)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] reg_val,
                                       input logic [31:0] wb_val, input logic [31:0] mem_val);
    if (sel == 2'd1) return wb_val;
    if (sel == 2'd2) return mem_val;
    return reg_val;
  endfunction

  task automatic model_eval();
    logic [31:0] a, fb, b, alu;
    int          sa, sb, sfb;
    a   = pick(ForwardAE, RD1_E, ResultW, m_alu);
    fb  = pick(ForwardBE, RD2_E, ResultW, m_alu);
    b   = ALUSrcE ? ImmExtE : fb;
    sa  = int'(a);
    sb  = int'(b);
    sfb = int'(fb);
    case (ALUControlE)
      3'd0: alu = a + b;
      3'd1: alu = a - b;
      3'd2: alu = a & b;
      3'd3: alu = a | b;
      3'd4: alu = a ^ b;
      3'd5: alu = (sa < sb) ? 32'd1 : 32'd0;
      3'd6: alu = a << (b % 32);
      default: alu = a >> (b % 32);
    endcase
    case (BranchE)
      3'd1: e_taken = (a == fb);
      3'd2: e_taken = (a != fb);
      3'd3: e_taken = (sa < sfb);
      3'd4: e_taken = (sa >= sfb);
      3'd5, 3'd6: e_taken = 1'b1;
      default: e_taken = 1'b0;
    endcase
    e_target = (BranchE == 3'd6) ? ((a + ImmExtE) & ~32'd1) : (PCE + ImmExtE);
    e_result = (BranchE == 3'd5 || BranchE == 3'd6) ? PCPlus4E : alu;
    e_store  = fb;
  endtask

  task automatic model_clear();
    {m_rw, m_mw, m_mr, m_rs} = 4'b0;
    m_alu = 32'd0;
    m_wd  = 32'd0;
    m_pc4 = 32'd0;
    m_rd  = 5'd0;
  endtask

  task automatic check_m(input string tag);
    check({tag, ".rw"},  {31'd0, RegWriteM},  {31'd0, m_rw});
    check({tag, ".mw"},  {31'd0, MemWriteM},  {31'd0, m_mw});
    check({tag, ".mr"},  {31'd0, MemReadM},   {31'd0, m_mr});
    check({tag, ".rs"},  {31'd0, ResultSrcM}, {31'd0, m_rs});
    check({tag, ".alu"}, ALUResultM, m_alu);
    check({tag, ".wd"},  WriteDataM, m_wd);
    check({tag, ".pc4"}, PCPlus4M,   m_pc4);
    check({tag, ".rd"},  {27'd0, RD_M}, {27'd0, m_rd});
  endtask

  // Inputs are already applied at the negedge; check redirect, clock, check EX/MEM.
  task automatic step(input string tag);
    #1;
    model_eval();
    check({tag, ".pcsrc"},  {31'd0, PCSrcE}, {31'd0, e_taken});
    check({tag, ".target"}, PCTargetE, e_target);
    @(posedge clk);
    if (FlushM) begin
      model_clear();
    end else if (!StallM) begin
      m_rw = RegWriteE; m_mw = MemWriteE; m_mr = MemReadE; m_rs = ResultSrcE;
      m_alu = e_result; m_wd = e_store; m_pc4 = PCPlus4E; m_rd = RD_E;
    end
    #1;
    check_m(tag);
  endtask

  task automatic defaults();
    {RegWriteE, ALUSrcE, MemWriteE, MemReadE, ResultSrcE} = 5'b0;
    BranchE = 3'd0; ALUControlE = 3'd0;
    RD1_E = 0; RD2_E = 0; ImmExtE = 0; PCE = 0; PCPlus4E = 0; ResultW = 0;
    RD_E = 0; ForwardAE = 0; ForwardBE = 0; StallM = 0; FlushM = 0;
  endtask

  task automatic randomize_inputs();
    {RegWriteE, ALUSrcE, MemWriteE, MemReadE, ResultSrcE} = 5'($urandom);
    BranchE     = 3'($urandom);
    ALUControlE = 3'($urandom);
    RD1_E    = $urandom;
    RD2_E    = ($urandom_range(3) == 0) ? RD1_E : $urandom;
    ImmExtE  = $urandom;
    PCE      = $urandom;
    PCPlus4E = PCE + 32'd4;
    ResultW  = $urandom;
    RD_E     = 5'($urandom);
    ForwardAE = 2'($urandom);
    ForwardBE = 2'($urandom);
    StallM   = ($urandom_range(3) == 0);
    FlushM   = ($urandom_range(7) == 0);
  endtask

  initial begin
    logic [31:0] held_alu;
    defaults();
    model_clear();
    #2;
    check_m("reset0");
    @(negedge clk);
    rst = 1'b1;

    // Forwarded subtract: ALUResultM = 7, then 7 - 3.
    @(negedge clk); defaults(); RD1_E = 7; RegWriteE = 1; RD_E = 5'd3;
    step("seed7");
    @(negedge clk); defaults(); RD1_E = 5; RD2_E = 3; ForwardAE = 2'b10; ALUControlE = 3'b001;
    step("fwd_sub");
    check("fwd_sub.val", ALUResultM, 32'd4);

    // Signed compares.
    @(negedge clk); defaults(); RD1_E = 32'hFFFF_FFFF; RD2_E = 1; BranchE = 3'b011;
    #1 check("blt.taken", {31'd0, PCSrcE}, 32'd1);
    step("blt");
    @(negedge clk); BranchE = 3'b100;
    #1 check("bge.taken", {31'd0, PCSrcE}, 32'd0);
    step("bge");
    @(negedge clk); BranchE = 3'b000; ALUControlE = 3'b101;
    step("slt");
    check("slt.val", ALUResultM, 32'd1);

    // jalr target and link.
    @(negedge clk); defaults(); RD1_E = 32'h1001; ImmExtE = 4; PCPlus4E = 32'h48;
    BranchE = 3'b110; RegWriteE = 1; PCE = 32'h44;
    #1 check("jalr.taken", {31'd0, PCSrcE}, 32'd1);
    check("jalr.target", PCTargetE, 32'h1004);
    step("jalr");
    check("jalr.link", ALUResultM, 32'h48);
    check("jalr.rw", {31'd0, RegWriteM}, 32'd1);

    // Hold for two cycles while inputs churn, then flush with stall still high.
    held_alu = ALUResultM;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); randomize_inputs(); StallM = 1; FlushM = 0;
      step("stall");
    end
    check("stall.held", ALUResultM, held_alu);
    @(negedge clk); randomize_inputs(); StallM = 1; FlushM = 1;
    step("flush");
    check("flush.alu", ALUResultM, 32'd0);

    // Store with forwarded data from writeback.
    @(negedge clk); defaults(); MemWriteE = 1; ALUSrcE = 1; ForwardBE = 2'b01;
    ResultW = 32'hDEAD_BEEF; RD1_E = 32'h100; ImmExtE = 32'h8; RD2_E = 32'h55;
    step("store");
    check("store.wd", WriteDataM, 32'hDEAD_BEEF);
    check("store.addr", ALUResultM, 32'h108);

    // Asynchronous reset between edges discards in-flight content.
    @(negedge clk); defaults(); RD1_E = 32'h1234; RegWriteE = 1; PCPlus4E = 32'h10; RD_E = 5'd9;
    step("pre_rst");
    #2 rst = 1'b0;
    model_clear();
    #1 check_m("async_rst");
    @(negedge clk); rst = 1'b1;

    for (int i = 0; i < 400; i++) begin
      @(negedge clk); randomize_inputs();
      step("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
